// File: rtl/nios_namedisplay_input_pio.sv
// rtl/nios_namedisplay_input_pio.sv - Avalon-MM input PIO with synchroniser, debouncer, edge capture and irq
module nios_namedisplay_input_pio #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt    [WIDTH];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] d_prev;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] wr_clr;
    logic [31:0]      rd_mux;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;
    assign s     = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // A new value must be seen on DEBOUNCE_CYCLES consecutive clocks before d follows it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d      <= '0;
            d_prev <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                cnt[b] <= '0;
            end
        end else begin
            d_prev <= d;
            for (int b = 0; b < WIDTH; b++) begin
                if (s[b] == d[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == CNT_LAST) begin
                    d[b]   <= s[b];
                    cnt[b] <= '0;
                end else begin
                    cnt[b] <= cnt[b] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        edge_evt = '0;
        case (EDGE_TYPE)
            1:       edge_evt = ~d & d_prev;
            2:       edge_evt = d ^ d_prev;
            default: edge_evt = d & ~d_prev;
        endcase
    end

    assign wr_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

    // A set on the same clock as a write-1-clear wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask     <= '0;
            edgecapture <= '0;
        end else begin
            if (wr_en && address == 2'd2) begin
                irqmask <= writedata[WIDTH-1:0];
            end
            edgecapture <= (edgecapture & ~wr_clr) | edge_evt;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux = 32'(d);
            2'd2:    rd_mux = 32'(irqmask);
            2'd3:    rd_mux = 32'(edgecapture);
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_nios_namedisplay_input_pio.sv
// tb/tb_nios_namedisplay_input_pio.sv - self-checking bench for nios_namedisplay_input_pio
module tb_nios_namedisplay_input_pio;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  in_port;
    logic [31:0] readdata, readdata_f, readdata_a;
    logic        irq, irq_f, irq_a;

    logic [31:0] sb [$];
    logic [31:0] exp;
    int          tests = 0;
    int          failed = 0;

    always #5 clk = ~clk;

    nios_namedisplay_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    nios_namedisplay_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut_f (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_f), .irq(irq_f)
    );

    nios_namedisplay_input_pio #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_a), .irq(irq_a)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_clks(input int n);
        repeat (n) step();
    endtask

    task automatic do_write(input logic [1:0] a, input logic [31:0] v);
        address    = a;
        writedata  = v;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
        writedata = '0; in_port = 4'h5;
        sb.push_back(32'h0);
        wait_clks(3);
        exp = sb.pop_front();
        tests++;
        if ({irq, readdata} !== {1'b0, exp}) begin
            failed++;
            $display("FAIL reset_state: irq=%b readdata=%h, want irq=0 readdata=%h", irq, readdata, exp);
        end
    endtask

    task automatic test_held_input();
        reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            sb.push_back(e < 7 ? 32'h0 : 32'h5);
            step();
            exp = sb.pop_front();
            tests++;
            if (readdata !== exp) begin
                failed++;
                $display("FAIL held_data edge %0d: got %h want %h", e, readdata, exp);
            end
        end
        address = 2'd3;
        sb.push_back(32'h5); sb.push_back(32'h0); sb.push_back(32'h5);
        step();
        exp = sb.pop_front(); tests++;
        if (readdata !== exp) begin failed++; $display("FAIL held_ec_rise: got %h want %h", readdata, exp); end
        exp = sb.pop_front(); tests++;
        if (readdata_f !== exp) begin failed++; $display("FAIL held_ec_fall: got %h want %h", readdata_f, exp); end
        exp = sb.pop_front(); tests++;
        if (readdata_a !== exp) begin failed++; $display("FAIL held_ec_any: got %h want %h", readdata_a, exp); end
    endtask

    task automatic test_bounce();
        do_write(2'd3, 32'hF);
        in_port = 4'h0;
        wait_clks(10);
        do_write(2'd3, 32'hF);
        do_write(2'd2, 32'hF);
        address = 2'd0;
        in_port = 4'h1;
        for (int e = 1; e <= 12; e++) begin
            sb.push_back(32'h0);
            step();
            exp = sb.pop_front();
            tests++;
            if ({irq, readdata} !== {1'b0, exp}) begin
                failed++;
                $display("FAIL bounce edge %0d: irq=%b data=%h want irq=0 data=%h", e, irq, readdata, exp);
            end
            if (e == 3) in_port = 4'h0;
        end
        address = 2'd3;
        sb.push_back(32'h0);
        step();
        exp = sb.pop_front(); tests++;
        if (readdata !== exp) begin failed++; $display("FAIL bounce_ec: got %h want %h", readdata, exp); end
    endtask

    task automatic test_irq_handshake();
        do_write(2'd2, 32'h1);
        address = 2'd0;
        in_port = 4'h1;
        for (int e = 1; e <= 7; e++) begin
            sb.push_back(e < 7 ? 32'h0 : 32'h1);
            step();
            exp = sb.pop_front();
            tests++;
            if ({irq, readdata} !== {(e == 7), exp}) begin
                failed++;
                $display("FAIL irq_rise edge %0d: irq=%b data=%h want irq=%b data=%h", e, irq, readdata, (e == 7), exp);
            end
        end
        do_write(2'd3, 32'h1);
        tests++;
        if (irq !== 1'b0) begin failed++; $display("FAIL irq_clear: irq=%b want 0", irq); end
        sb.push_back(32'h0);
        step();
        exp = sb.pop_front(); tests++;
        if (readdata !== exp) begin failed++; $display("FAIL irq_clear_ec: got %h want %h", readdata, exp); end

        in_port = 4'h0;
        wait_clks(10);
        do_write(2'd3, 32'hF);
        in_port = 4'h3;
        wait_clks(9);
        do_write(2'd3, 32'h0);
        sb.push_back(32'h3);
        step();
        exp = sb.pop_front(); tests++;
        if ({irq, readdata} !== {1'b1, exp}) begin
            failed++;
            $display("FAIL write0_keeps: irq=%b ec=%h want irq=1 ec=%h", irq, readdata, exp);
        end
    endtask

    task automatic test_collision();
        do_write(2'd3, 32'hF);
        in_port = 4'h0;
        wait_clks(10);
        do_write(2'd3, 32'hF);
        in_port = 4'h1;
        wait_clks(6);
        tests++;
        if (irq !== 1'b0) begin failed++; $display("FAIL collision_pre: irq=%b want 0", irq); end
        do_write(2'd3, 32'h1);
        tests++;
        if (irq !== 1'b1) begin failed++; $display("FAIL collision_irq: irq=%b want 1", irq); end
        sb.push_back(32'h1);
        step();
        exp = sb.pop_front(); tests++;
        if ({irq, readdata} !== {1'b1, exp}) begin
            failed++;
            $display("FAIL collision_ec: irq=%b ec=%h want irq=1 ec=%h", irq, readdata, exp);
        end
    endtask

    task automatic test_reset_mid();
        do_write(2'd2, 32'hF);
        address = 2'd3;
        in_port = 4'h5;
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        sb.push_back(32'h0);
        exp = sb.pop_front(); tests++;
        if ({irq, readdata} !== {1'b0, exp}) begin
            failed++;
            $display("FAIL async_reset: irq=%b data=%h want irq=0 data=%h", irq, readdata, exp);
        end
        @(posedge clk);
        step();
        reset_n = 1'b1;
        address = 2'd2;
        for (int e = 1; e <= 7; e++) begin
            sb.push_back(e < 7 ? 32'h0 : 32'h5);
            step();
            exp = sb.pop_front(); tests++;
            if (readdata !== exp) begin
                failed++;
                $display("FAIL reset_relatency edge %0d addr %0d: got %h want %h", e, address, readdata, exp);
            end
            if (e == 1) address = 2'd3;
            if (e == 2) address = 2'd0;
        end
        step();
        tests++;
        if (irq !== 1'b0) begin failed++; $display("FAIL reset_mask_cleared: irq=%b want 0", irq); end
    endtask

    task automatic test_edge_modes();
        do_write(2'd3, 32'hF);
        address = 2'd3;
        in_port = 4'h7;
        wait_clks(9);
        sb.push_back(32'h2); sb.push_back(32'h0); sb.push_back(32'h2);
        step();
        exp = sb.pop_front(); tests++;
        if (readdata !== exp) begin failed++; $display("FAIL mode_rise_on_rise: got %h want %h", readdata, exp); end
        exp = sb.pop_front(); tests++;
        if (readdata_f !== exp) begin failed++; $display("FAIL mode_fall_on_rise: got %h want %h", readdata_f, exp); end
        exp = sb.pop_front(); tests++;
        if (readdata_a !== exp) begin failed++; $display("FAIL mode_any_on_rise: got %h want %h", readdata_a, exp); end
        do_write(2'd3, 32'h2);
        in_port = 4'h5;
        wait_clks(9);
        sb.push_back(32'h0); sb.push_back(32'h2); sb.push_back(32'h2);
        step();
        exp = sb.pop_front(); tests++;
        if (readdata !== exp) begin failed++; $display("FAIL mode_rise_on_fall: got %h want %h", readdata, exp); end
        exp = sb.pop_front(); tests++;
        if (readdata_f !== exp) begin failed++; $display("FAIL mode_fall_on_fall: got %h want %h", readdata_f, exp); end
        exp = sb.pop_front(); tests++;
        if (readdata_a !== exp) begin failed++; $display("FAIL mode_any_on_fall: got %h want %h", readdata_a, exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_held_input();
        test_bounce();
        test_irq_handshake();
        test_collision();
        test_reset_mid();
        test_edge_modes();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
